// File: rtl/hack_alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hack_alu_sequencer_pkg
// Description : Shared definitions for the Hack control core: FSM state
//               encoding, instruction-register field positions and the
//               jump-condition bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_alu_sequencer_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_READ   = ST_READ,
        S_EXEC   = ST_EXEC,
        S_WRITE  = ST_WRITE
    } state_t;

    // Instruction register fields
    localparam int IR_CI = 15;  // 1 = C-instruction, 0 = A-instruction
    localparam int IR_A  = 12;  // ALU y operand: 1 = M-latch, 0 = A
    localparam int IR_ZX = 11;
    localparam int IR_NX = 10;
    localparam int IR_ZY = 9;
    localparam int IR_NY = 8;
    localparam int IR_F  = 7;
    localparam int IR_NO = 6;
    localparam int IR_DA = 5;
    localparam int IR_DD = 4;
    localparam int IR_DM = 3;

    // Jump condition bits
    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

endpackage : hack_alu_sequencer_pkg
`default_nettype wire

// File: rtl/hack_alu_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : hack_alu_sequencer_alu
// Description : Combinational 16-bit Hack ALU.
//               i_x, i_y           : operands
//               i_zx/i_nx          : zero / invert x
//               i_zy/i_ny          : zero / invert y
//               i_f                : 1 = add, 0 = and
//               i_no               : invert result
//               o_out, o_zr, o_ng  : result, result==0, result<0
// Revision    : 1.0 - initial release
// ============================================================================
module hack_alu_sequencer_alu (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_zx,
    input  logic        i_nx,
    input  logic        i_zy,
    input  logic        i_ny,
    input  logic        i_f,
    input  logic        i_no,
    output logic [15:0] o_out,
    output logic        o_zr,
    output logic        o_ng
);

    logic [15:0] w_x0;
    logic [15:0] w_x1;
    logic [15:0] w_y0;
    logic [15:0] w_y1;
    logic [15:0] w_fn;

    assign w_x0  = i_zx ? 16'h0000 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? 16'h0000 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    assign w_fn  = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_fn : w_fn;
    assign o_zr  = (o_out == 16'h0000);
    assign o_ng  = o_out[15];

endmodule : hack_alu_sequencer_alu
`default_nettype wire

// File: rtl/hack_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hack_alu_sequencer
// Description : Multi-cycle Hack-ISA control core. Fetches instructions over
//               a valid handshake, decodes C-instruction comp bits onto the
//               ALU controls, owns A, D and PC, and performs M reads/writes
//               over valid/ack handshakes.
//               clk, rst_n                     : clock, async active-low reset
//               imem_req/addr/rdata/valid      : instruction ROM port
//               dmem_addr/rd/rdata/rvalid      : data RAM read port
//               dmem_wr/wdata/wack             : data RAM write port
//               pc                             : current PC (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module hack_alu_sequencer
    import hack_alu_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_rd,
    input  logic [15:0]       dmem_rdata,
    input  logic              dmem_rvalid,
    output logic              dmem_wr,
    output logic [15:0]       dmem_wdata,
    input  logic              dmem_wack,
    output logic [ADDR_W-1:0] pc
);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_ir;
    logic [15:0]       r_a;
    logic [15:0]       r_d;
    logic [15:0]       r_m;
    logic [15:0]       r_wdata;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_waddr;

    logic [15:0]       w_y;
    logic [15:0]       w_out;
    logic              w_zr;
    logic              w_ng;
    logic              w_jump;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_y      = r_ir[IR_A] ? r_m : r_a;
    assign w_pc_inc = r_pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
    assign w_jump   = (r_ir[JMP_LT] & w_ng)
                    | (r_ir[JMP_EQ] & w_zr)
                    | (r_ir[JMP_GT] & ~w_zr & ~w_ng);

    hack_alu_sequencer_alu u_alu (
        .i_x   (r_d),
        .i_y   (w_y),
        .i_zx  (r_ir[IR_ZX]),
        .i_nx  (r_ir[IR_NX]),
        .i_zy  (r_ir[IR_ZY]),
        .i_ny  (r_ir[IR_NY]),
        .i_f   (r_ir[IR_F]),
        .i_no  (r_ir[IR_NO]),
        .o_out (w_out),
        .o_zr  (w_zr),
        .o_ng  (w_ng)
    );

    assign imem_addr = r_pc;
    assign pc        = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = 16'h0000;
        case (r_state)
            S_FETCH: begin
                // The state register already sits in FETCH during reset;
                // qualifying with rst_n keeps the request low until release.
                imem_req = rst_n;
                if (imem_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!r_ir[IR_CI]) begin
                    w_next = S_FETCH;
                end else if (r_ir[IR_A]) begin
                    w_next = S_READ;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_READ: begin
                dmem_rd   = 1'b1;
                dmem_addr = r_a[ADDR_W-1:0];
                if (dmem_rvalid) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = r_ir[IR_DM] ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                dmem_wr    = 1'b1;
                dmem_addr  = r_waddr;
                dmem_wdata = r_wdata;
                if (dmem_wack) begin
                    w_next = S_FETCH;
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= 16'h0000;
            r_a     <= 16'h0000;
            r_d     <= 16'h0000;
            r_m     <= 16'h0000;
            r_wdata <= 16'h0000;
            r_waddr <= '0;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir <= imem_rdata;
                    end
                end
                S_DECODE: begin
                    if (!r_ir[IR_CI]) begin
                        r_a  <= {1'b0, r_ir[IR_CI-1:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                S_READ: begin
                    if (dmem_rvalid) begin
                        r_m <= dmem_rdata;
                    end
                end
                S_EXEC: begin
                    // Jump target and write address read r_a before the
                    // dA update lands, so they always see the old A.
                    if (r_ir[IR_DD]) begin
                        r_d <= w_out;
                    end
                    if (r_ir[IR_DA]) begin
                        r_a <= w_out;
                    end
                    r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
                    if (r_ir[IR_DM]) begin
                        r_waddr <= r_a[ADDR_W-1:0];
                        r_wdata <= w_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : hack_alu_sequencer
`default_nettype wire

// File: tb/tb_hack_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_alu_sequencer
// Description : Self-checking bench for hack_alu_sequencer. ROM/RAM
//               responders with programmable wait states log every fetch and
//               write; an instruction-level Hack model predicts the traces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_alu_sequencer;

    localparam int ADDR_W = 15;
    localparam int MEM_N  = 1 << ADDR_W;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata = 16'h0000;
    logic              imem_valid = 1'b0;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_rd;
    logic [15:0]       dmem_rdata = 16'h0000;
    logic              dmem_rvalid = 1'b0;
    logic              dmem_wr;
    logic [15:0]       dmem_wdata;
    logic              dmem_wack = 1'b0;
    logic [ADDR_W-1:0] pc;

    logic [15:0] rom  [0:MEM_N-1];
    logic [15:0] ram  [0:MEM_N-1];
    logic [15:0] mram [0:MEM_N-1];

    int  fetch_q[$];
    int  fetch_cyc[$];
    wr_t wr_q[$];
    int  exp_fetch[$];
    wr_t exp_wr[$];

    int          cyc = 0;
    int          max_wait = 0;
    int          rd_force = -1;
    bit          wr_hold = 1'b0;
    int          rom_wait = 0;
    int          rd_wait = 0;
    int          wr_wait = 0;
    int          rd_run_len = 0;
    int          last_rd_len = 0;
    logic [14:0] rd_run_addr = '0;
    bit          rd_addr_moved = 1'b0;

    int checks = 0;
    int errors = 0;

    hack_alu_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (15'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .dmem_addr   (dmem_addr),
        .dmem_rd     (dmem_rd),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_wr     (dmem_wr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wack   (dmem_wack),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Memory responders and bus monitor, acting on the falling edge.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (!rst_n) begin
            imem_valid  = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_wack   = 1'b0;
            rom_wait    = 0;
            rd_wait     = (rd_force >= 0) ? rd_force : 0;
            wr_wait     = 0;
            rd_run_len  = 0;
        end else begin
            if (dmem_rd || dmem_wr) begin
                checks++;
                if (dmem_rd && dmem_wr) begin
                    errors++;
                    $display("FAIL rd_wr_exclusive: rd=%0b wr=%0b, required not both", dmem_rd, dmem_wr);
                end
                if (imem_req) begin
                    errors++;
                    $display("FAIL imem_req_outside_fetch: imem_req=%0b, required 0", imem_req);
                end
            end
            imem_valid = 1'b0;
            if (imem_req) begin
                if (rom_wait == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = rom[imem_addr];
                    fetch_q.push_back(int'(imem_addr));
                    fetch_cyc.push_back(cyc);
                    rom_wait = $urandom_range(0, max_wait);
                end else begin
                    rom_wait--;
                end
            end
            dmem_rvalid = 1'b0;
            if (dmem_rd) begin
                if (rd_run_len == 0) begin
                    rd_run_addr = dmem_addr;
                end else if (dmem_addr != rd_run_addr) begin
                    rd_addr_moved = 1'b1;
                end
                rd_run_len++;
                if (rd_wait == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = ram[dmem_addr];
                    last_rd_len = rd_run_len;
                    rd_run_len  = 0;
                    rd_wait     = (rd_force >= 0) ? rd_force : int'($urandom_range(0, max_wait));
                end else begin
                    rd_wait--;
                end
            end
            dmem_wack = 1'b0;
            if (dmem_wr && !wr_hold) begin
                if (wr_wait == 0) begin
                    dmem_wack = 1'b1;
                    ram[dmem_addr] = dmem_wdata;
                    w.addr = dmem_addr;
                    w.data = dmem_wdata;
                    wr_q.push_back(w);
                    wr_wait = $urandom_range(0, max_wait);
                end else begin
                    wr_wait--;
                end
            end
        end
    end

    // Instruction-level reference: executes n instructions from reset state.
    task automatic model_run(input int n);
        logic [15:0] a, d, x, y, o, ins;
        int          mpc;
        bit          taken;
        wr_t         w;
        a = 16'h0000;
        d = 16'h0000;
        mpc = 0;
        exp_fetch.delete();
        exp_wr.delete();
        for (int k = 0; k < n; k++) begin
            exp_fetch.push_back(mpc);
            ins = rom[mpc];
            if (!ins[15]) begin
                a   = {1'b0, ins[14:0]};
                mpc = (mpc + 1) % MEM_N;
            end else begin
                x = d;
                y = ins[12] ? mram[a[14:0]] : a;
                if (ins[11]) x = 16'h0000;
                if (ins[10]) x = ~x;
                if (ins[9])  y = 16'h0000;
                if (ins[8])  y = ~y;
                o = ins[7] ? (x + y) : (x & y);
                if (ins[6])  o = ~o;
                taken = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0000) ||
                        (ins[0] && $signed(o) > 0);
                if (ins[3]) begin
                    mram[a[14:0]] = o;
                    w.addr = a[14:0];
                    w.data = o;
                    exp_wr.push_back(w);
                end
                mpc = taken ? int'(a[14:0]) : (mpc + 1) % MEM_N;
                if (ins[5]) a = o;
                if (ins[4]) d = o;
            end
        end
        exp_fetch.push_back(mpc);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_N; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fetch_q.delete();
        fetch_cyc.delete();
        wr_q.delete();
        #2 rst_n = 1'b1;
    endtask

    // Runs until the fetch of instruction n+1 is seen or the budget runs out.
    task automatic run_program(input int n, input int budget, output bit timeout);
        for (int c = 0; c < budget && fetch_q.size() < n + 1; c++) begin
            @(posedge clk);
        end
        #1;
        timeout = (fetch_q.size() < n + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (imem_req !== 1'b0 || dmem_rd !== 1'b0 || dmem_wr !== 1'b0 ||
            dmem_addr !== 15'h0 || dmem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b rd=%0b wr=%0b addr=%0h wdata=%0h, required all 0",
                     imem_req, dmem_rd, dmem_wr, dmem_addr, dmem_wdata);
        end
        checks++;
        if (pc !== 15'h0 || imem_addr !== 15'h0) begin
            errors++;
            $display("FAIL reset_pc: pc=%0h imem_addr=%0h, required 0", pc, imem_addr);
        end
        apply_reset();
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: imem_req=%0b, required 1", imem_req);
        end
    endtask

    task automatic test_program();
        bit to;
        int exp_f[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        clear_mem();
        max_wait = 0; rd_force = -1; wr_hold = 1'b0;
        rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE090;
        rom[4] = 16'h0000; rom[5] = 16'hE308; rom[6] = 16'hEC08;
        apply_reset();
        run_program(7, 500, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL program_timeout: fetches=%0d, required 8", fetch_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fetch_q[i] !== exp_f[i]) begin
                errors++;
                $display("FAIL program_fetch[%0d]: got %0h, required %0h", i, fetch_q[i], exp_f[i]);
            end
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[0].addr !== 15'h0 || wr_q[0].data !== 16'h0005 ||
            wr_q[1].addr !== 15'h0 || wr_q[1].data !== 16'h0000) begin
            errors++;
            $display("FAIL program_writes: n=%0d first=(%0h,%0h), required (0,5) then (0,0)",
                     wr_q.size(), wr_q[0].addr, wr_q[0].data);
        end
        checks++;
        if (fetch_cyc[6] - fetch_cyc[0] != 16) begin
            errors++;
            $display("FAIL program_latency: got %0d cycles, required 16", fetch_cyc[6] - fetch_cyc[0]);
        end
    endtask

    task automatic test_jump();
        bit to;
        int exp_f[10] = '{0, 1, 2, 10, 11, 12, 4, 5, 6, 30};
        clear_mem();
        max_wait = 1; rd_force = -1; wr_hold = 1'b0;
        rom[0]  = 16'hEE90; rom[1]  = 16'h000A; rom[2] = 16'hE304;
        rom[10] = 16'hEA90; rom[11] = 16'h0004; rom[12] = 16'hEA87;
        rom[4]  = 16'hE301; rom[5]  = 16'h001E; rom[6] = 16'hE302;
        apply_reset();
        run_program(9, 500, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL jump_timeout: fetches=%0d, required 10", fetch_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fetch_q[i] !== exp_f[i]) begin
                errors++;
                $display("FAIL jump_fetch[%0d]: got %0d, required %0d", i, fetch_q[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_old_a();
        bit to;
        clear_mem();
        max_wait = 0; rd_force = -1; wr_hold = 1'b0;
        rom[0] = 16'h0007; rom[1] = 16'hEDE8; rom[2] = 16'hEC08;
        apply_reset();
        run_program(3, 300, to);
        checks++;
        if (to || wr_q.size() != 2) begin
            errors++;
            $display("FAIL old_a_count: writes=%0d timeout=%0b, required 2 writes", wr_q.size(), to);
        end
        checks++;
        if (wr_q[0].addr !== 15'd7 || wr_q[0].data !== 16'd8) begin
            errors++;
            $display("FAIL old_a_write: got (%0h,%0h), required (7,8)", wr_q[0].addr, wr_q[0].data);
        end
        checks++;
        if (wr_q[1].addr !== 15'd8 || wr_q[1].data !== 16'd8) begin
            errors++;
            $display("FAIL old_a_new_a: got (%0h,%0h), required (8,8)", wr_q[1].addr, wr_q[1].data);
        end
    endtask

    task automatic test_mread_delay();
        bit to;
        clear_mem();
        max_wait = 0; rd_force = 3; wr_hold = 1'b0;
        rd_addr_moved = 1'b0; last_rd_len = 0;
        ram[16'h20] = 16'd129;
        rom[0] = 16'h002A; rom[1] = 16'hEC10; rom[2] = 16'h0020; rom[3] = 16'hF4D0;
        rom[4] = 16'hE308;
        apply_reset();
        run_program(5, 300, to);
        checks++;
        if (to || last_rd_len != 4 || rd_addr_moved || rd_run_addr !== 15'h20) begin
            errors++;
            $display("FAIL mread_hold: len=%0d moved=%0b addr=%0h timeout=%0b, required 4,0,20,0",
                     last_rd_len, rd_addr_moved, rd_run_addr, to);
        end
        checks++;
        if (wr_q.size() != 1 || wr_q[0].addr !== 15'h20 || wr_q[0].data !== 16'hFFA9) begin
            errors++;
            $display("FAIL mread_result: got (%0h,%0h) n=%0d, required (20,ffa9)",
                     wr_q[0].addr, wr_q[0].data, wr_q.size());
        end
        rd_force = -1;
    endtask

    task automatic test_reset_mid_write();
        bit to;
        bit seen;
        clear_mem();
        max_wait = 0; rd_force = -1; wr_hold = 1'b1;
        rom[0] = 16'h0009; rom[1] = 16'hEC10; rom[2] = 16'hE308;
        apply_reset();
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            #1 seen = dmem_wr;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midwr_reach_write: dmem_wr=%0b, required 1", dmem_wr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_wr !== 1'b0 || imem_req !== 1'b0 || pc !== 15'h0 || dmem_addr !== 15'h0) begin
            errors++;
            $display("FAIL midwr_async: wr=%0b req=%0b pc=%0h addr=%0h, required 0,0,0,0",
                     dmem_wr, imem_req, pc, dmem_addr);
        end
        wr_hold = 1'b0;
        rom[0] = 16'hE308; rom[1] = 16'h0000; rom[2] = 16'h0000;
        apply_reset();
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwr_req_after_release: imem_req=%0b, required 1", imem_req);
        end
        run_program(1, 100, to);
        checks++;
        if (to || fetch_q[0] != 0 || fetch_q[1] != 1 || wr_q.size() != 1 ||
            wr_q[0].addr !== 15'h0 || wr_q[0].data !== 16'h0) begin
            errors++;
            $display("FAIL midwr_clean_state: f0=%0d f1=%0d n=%0d w=(%0h,%0h), required 0,1,1,(0,0)",
                     fetch_q[0], fetch_q[1], wr_q.size(), wr_q[0].addr, wr_q[0].data);
        end
    endtask

    task automatic test_pc_wrap();
        bit to;
        int exp_f[6] = '{0, 1, 2, 32767, 0, 32767};
        clear_mem();
        max_wait = 0; rd_force = -1; wr_hold = 1'b0;
        rom[0] = 16'hEC0D; rom[1] = 16'h7FFF; rom[2] = 16'hEA87; rom[32767] = 16'h7FFF;
        apply_reset();
        run_program(5, 300, to);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (fetch_q[i] !== exp_f[i]) begin
                errors++;
                $display("FAIL wrap_fetch[%0d]: got %0h, required %0h", i, fetch_q[i], exp_f[i]);
            end
        end
        checks++;
        if (to || wr_q.size() != 2 || wr_q[1].addr !== 15'h7FFF || wr_q[1].data !== 16'h7FFF) begin
            errors++;
            $display("FAIL wrap_a: got (%0h,%0h) n=%0d, required (7fff,7fff)",
                     wr_q[1].addr, wr_q[1].data, wr_q.size());
        end
    endtask

    task automatic test_random();
        bit to;
        int n = 40;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < MEM_N; i++) begin
                rom[i] = (i % 2 == 0) ? 16'h0000 : 16'hEA87;
                ram[i] = (i < 64) ? 16'($urandom) : 16'h0000;
            end
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    rom[i] = 16'($urandom_range(0, 63));
                end else begin
                    rom[i] = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom),
                              ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000};
                end
            end
            max_wait = 3; rd_force = -1; wr_hold = 1'b0;
            mram = ram;
            model_run(n);
            apply_reset();
            run_program(n, 2000, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL rand%0d_timeout: fetches=%0d, required %0d", p, fetch_q.size(), n + 1);
            end
            for (int i = 0; i <= n; i++) begin
                checks++;
                if (fetch_q[i] !== exp_fetch[i]) begin
                    errors++;
                    $display("FAIL rand%0d_fetch[%0d]: got %0h, required %0h", p, i, fetch_q[i], exp_fetch[i]);
                end
            end
            checks++;
            if (wr_q.size() != exp_wr.size()) begin
                errors++;
                $display("FAIL rand%0d_wr_count: got %0d, required %0d", p, wr_q.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i].addr !== exp_wr[i].addr || wr_q[i].data !== exp_wr[i].data) begin
                    errors++;
                    $display("FAIL rand%0d_wr[%0d]: got (%0h,%0h), required (%0h,%0h)", p, i,
                             wr_q[i].addr, wr_q[i].data, exp_wr[i].addr, exp_wr[i].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_jump();
        test_old_a();
        test_mread_delay();
        test_reset_mid_write();
        test_pc_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hack_alu_sequencer
`default_nettype wire
